// File: rtl/icache_pkg.sv
// Shared types and helpers for the instruction line cache.
package icache_pkg;

    localparam int LINE_W         = 128;
    localparam int WORD_W         = 32;
    localparam int OFFSET_W       = 4;
    localparam int WORDS_PER_LINE = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        FILL   = 2'd2
    } state_t;

    // Select 32-bit word w of a line; word 0 holds the lowest-addressed bytes.
    function automatic logic [WORD_W-1:0] word_sel(input logic [LINE_W-1:0] line,
                                                  input logic [1:0]        w);
        return line[w*WORD_W +: WORD_W];
    endfunction

endpackage

// File: rtl/icache_line_store.sv
// Direct-mapped tag/data/valid storage: combinational lookup, synchronous fill.
module icache_line_store
    import icache_pkg::*;
#(
    parameter int NUM_LINES = 4,
    parameter int TAG_W     = 26
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic [$clog2(NUM_LINES)-1:0] rd_index,
    input  logic [TAG_W-1:0]             rd_tag,
    input  logic [1:0]                   rd_wsel,
    output logic                         rd_hit,
    output logic [WORD_W-1:0]            rd_word,
    input  logic                         wr_en,
    input  logic [$clog2(NUM_LINES)-1:0] wr_index,
    input  logic [TAG_W-1:0]             wr_tag,
    input  logic [LINE_W-1:0]            wr_line
);

    localparam int IDX_W = $clog2(NUM_LINES);

    logic [NUM_LINES-1:0] valid;
    logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
    logic [LINE_W-1:0]    data_mem [NUM_LINES];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LINES; gi++) begin : g_valid
            // A fill beats a simultaneous flush for its own line only.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid[gi] <= 1'b0;
                end else if (wr_en && (wr_index == IDX_W'(gi))) begin
                    valid[gi] <= 1'b1;
                end else if (flush) begin
                    valid[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    // Tag and data are never reset; valid alone qualifies them.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_index]  <= wr_tag;
            data_mem[wr_index] <= wr_line;
        end
    end

    // Lookup of the latched request address.
    always_comb begin
        rd_hit  = valid[rd_index] && (tag_mem[rd_index] == rd_tag);
        rd_word = word_sel(data_mem[rd_index], rd_wsel);
    end

endmodule

// File: rtl/icache_fetch_ctrl.sv
// Fetch controller: serves CPU word fetches from a direct-mapped line cache,
// refilling from a handshake-less instruction memory after a fixed wait.
module icache_fetch_ctrl
    import icache_pkg::*;
#(
    parameter int NUM_LINES = 4,
    parameter int MEM_WAIT  = 8,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic [31:0]       cpu_addr,
    output logic              cpu_ready,
    output logic [31:0]       cpu_instr,
    input  logic              flush,
    output logic [31:0]       mem_addr,
    input  logic [127:0]      mem_line,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TAG_W  = 32 - OFFSET_W - IDX_W;
    localparam int WAIT_W = $clog2(MEM_WAIT + 1);

    state_t            state;
    logic [31:0]       req_addr;
    logic [WAIT_W-1:0] wait_cnt;
    logic              lookup_hit;
    logic [WORD_W-1:0] lookup_word;
    logic              fill_en;
    logic              unused_bits;

    // Byte-within-word bits never influence a fetch.
    assign unused_bits = ^req_addr[1:0];

    // Capture edge: memory output has been stable for the full wait window.
    assign fill_en = (state == FILL) && (wait_cnt == WAIT_W'(MEM_WAIT - 1));

    icache_line_store #(
        .NUM_LINES (NUM_LINES),
        .TAG_W     (TAG_W)
    ) u_store (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .rd_index (req_addr[OFFSET_W +: IDX_W]),
        .rd_tag   (req_addr[31 -: TAG_W]),
        .rd_wsel  (req_addr[3:2]),
        .rd_hit   (lookup_hit),
        .rd_word  (lookup_word),
        .wr_en    (fill_en),
        .wr_index (req_addr[OFFSET_W +: IDX_W]),
        .wr_tag   (req_addr[31 -: TAG_W]),
        .wr_line  (mem_line)
    );

    // Request FSM with registered handshake, memory address and statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            req_addr   <= '0;
            wait_cnt   <= '0;
            cpu_ready  <= 1'b0;
            cpu_instr  <= '0;
            mem_addr   <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            cpu_ready <= 1'b0;
            case (state)
                IDLE: begin
                    // Never re-accept in the ready cycle of the previous fetch.
                    if (cpu_req && !cpu_ready) begin
                        req_addr <= cpu_addr;
                        state    <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (lookup_hit) begin
                        cpu_instr <= lookup_word;
                        cpu_ready <= 1'b1;
                        if (hit_count != '1) begin
                            hit_count <= hit_count + 1'b1;
                        end
                        state <= IDLE;
                    end else begin
                        mem_addr <= {req_addr[31:OFFSET_W], {OFFSET_W{1'b0}}};
                        wait_cnt <= '0;
                        if (miss_count != '1) begin
                            miss_count <= miss_count + 1'b1;
                        end
                        state <= FILL;
                    end
                end
                FILL: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (fill_en) begin
                        cpu_instr <= word_sel(mem_line, req_addr[3:2]);
                        cpu_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_fetch_ctrl.sv
// Bench for icache_fetch_ctrl: default instance plus a 2-bit-counter instance,
// each against a memory model with an 8-edge address-to-data pipeline.
module tb_icache_fetch_ctrl;

    localparam int MEM_WAIT = 8;
    localparam int PIPE_D   = 7;

    logic         clk;
    logic         rst_n;
    logic         flush;
    logic         req   [2];
    logic [31:0]  addr  [2];
    logic         rdy   [2];
    logic [31:0]  instr [2];
    logic [31:0]  maddr [2];
    logic [127:0] mline [2];
    logic [15:0]  hc0, mc0;
    logic [1:0]   hc1, mc1;
    logic         flush_sat;

    logic [31:0]  pipe [2][PIPE_D];
    logic         mem_ok [2];

    int n_checks;
    int n_fail;

    // reference model: per-instance cache contents and statistics
    bit          m_valid [2][4];
    logic [25:0] m_tag   [2][4];
    int          m_hits  [2];
    int          m_miss  [2];
    logic [31:0] m_maddr [2];

    icache_fetch_ctrl dut (
        .clk(clk), .rst_n(rst_n), .cpu_req(req[0]), .cpu_addr(addr[0]),
        .cpu_ready(rdy[0]), .cpu_instr(instr[0]), .flush(flush),
        .mem_addr(maddr[0]), .mem_line(mline[0]),
        .hit_count(hc0), .miss_count(mc0)
    );

    icache_fetch_ctrl #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .cpu_req(req[1]), .cpu_addr(addr[1]),
        .cpu_ready(rdy[1]), .cpu_instr(instr[1]), .flush(flush_sat),
        .mem_addr(maddr[1]), .mem_line(mline[1]),
        .hit_count(hc1), .miss_count(mc1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [127:0] line_of(input logic [31:0] a);
        logic [127:0] l;
        for (int k = 0; k < 16; k++) l[8*k +: 8] = 8'(a + 32'(k));
        return l;
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        logic [31:0] b;
        b = {a[31:2], 2'b00};
        return {8'(b + 3), 8'(b + 2), 8'(b + 1), 8'(b)};
    endfunction

    // memory: address travels through a pipeline; data is garbage until settled
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            pipe[i][0] <= maddr[i];
            for (int s = 1; s < PIPE_D; s++) pipe[i][s] <= pipe[i][s-1];
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            mem_ok[i] = 1'b1;
            for (int s = 0; s < PIPE_D; s++) begin
                if (pipe[i][s] != maddr[i]) mem_ok[i] = 1'b0;
            end
            mline[i] = mem_ok[i] ? line_of(maddr[i]) : {4{32'hDEADBEEF}};
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] get_hc(input int inst);
        return (inst == 0) ? hc0 : {14'b0, hc1};
    endfunction

    function automatic logic [15:0] get_mc(input int inst);
        return (inst == 0) ? mc0 : {14'b0, mc1};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 4; j++) m_valid[i][j] = 0;
            m_hits[i]  = 0;
            m_miss[i]  = 0;
            m_maddr[i] = 32'h0;
        end
    endtask

    task automatic pulse_flush();
        req[0] = 1'b0;
        flush  = 1'b1;
        @(posedge clk); #1;
        flush  = 1'b0;
        for (int j = 0; j < 4; j++) m_valid[0][j] = 0;
        $display("flush pulse");
    endtask

    // One fetch. hold keeps cpu_req high past ready; flush_k raises flush for
    // the edge after observation k; abort_k pulls reset after observation k.
    task automatic fetch(input int inst, input logic [31:0] a, input bit hold,
                         input int flush_k, input bit wiggle, input int abort_k);
        bit   exp_hit;
        int   idx;
        int   k;
        bit   seen;
        int   cmax;
        logic [25:0] tg;
        idx  = int'(a[5:4]);
        tg   = a[31:6];
        cmax = (inst == 0) ? 65535 : 3;
        exp_hit = m_valid[inst][idx] && (m_tag[inst][idx] == tg);
        req[inst]  = 1'b1;
        addr[inst] = a;
        @(posedge clk); #1;                     // accept edge
        if (wiggle) addr[inst] = $urandom;      // latched address must win
        if (exp_hit) begin
            if (m_hits[inst] < cmax) m_hits[inst]++;
        end else begin
            if (m_miss[inst] < cmax) m_miss[inst]++;
            m_maddr[inst] = {a[31:4], 4'h0};
        end
        seen = 0;
        k    = 0;
        while (!seen && k < 40) begin
            @(posedge clk); #1;
            k++;
            if (k == abort_k) begin
                rst_n = 1'b0;
                #1;
                check_eq("abort_ready", 64'(rdy[inst]), 64'd0);
                check_eq("abort_mem_addr", 64'(maddr[inst]), 64'd0);
                check_eq("abort_hits", 64'(get_hc(inst)), 64'd0);
                check_eq("abort_misses", 64'(get_mc(inst)), 64'd0);
                model_reset();
                req[inst] = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                @(posedge clk); #1;
                $display("fetch inst=%0d addr=%08h aborted by reset at k=%0d", inst, a, k);
                return;
            end
            flush = (k == flush_k);
            if (rdy[inst]) seen = 1;
            else if (!exp_hit && k < MEM_WAIT + 1)
                check_eq("mem_addr_hold", 64'(maddr[inst]), 64'(m_maddr[inst]));
        end
        flush = 1'b0;
        if (!seen) begin
            check_eq("ready_timeout", 64'(seen), 64'd1);
            req[inst] = 1'b0;
            return;
        end
        if (!hold) req[inst] = 1'b0;
        check_eq("latency", 64'(k + 1), exp_hit ? 64'd2 : 64'(MEM_WAIT + 2));
        check_eq("instr", 64'(instr[inst]), 64'(exp_word(a)));
        check_eq("mem_addr", 64'(maddr[inst]), 64'(m_maddr[inst]));
        check_eq("hit_count", 64'(get_hc(inst)), 64'(m_hits[inst]));
        check_eq("miss_count", 64'(get_mc(inst)), 64'(m_miss[inst]));
        if (!exp_hit) begin
            if (flush_k >= 0) for (int j = 0; j < 4; j++) m_valid[inst][j] = 0;
            m_valid[inst][idx] = 1;
            m_tag[inst][idx]   = tg;
        end
        @(posedge clk); #1;
        check_eq("ready_pulse", 64'(rdy[inst]), 64'd0);
        $display("fetch inst=%0d addr=%08h %s instr=%08h lat=%0d hits=%0d misses=%0d",
                 inst, a, exp_hit ? "hit " : "miss", instr[inst], k + 1,
                 get_hc(inst), get_mc(inst));
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        flush_sat = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req[i]  = 1'b0;
            addr[i] = 32'h0;
        end
        model_reset();
        #2;
        for (int i = 0; i < 2; i++) begin
            check_eq("rst_ready", 64'(rdy[i]), 64'd0);
            check_eq("rst_instr", 64'(instr[i]), 64'd0);
            check_eq("rst_mem_addr", 64'(maddr[i]), 64'd0);
            check_eq("rst_hits", 64'(get_hc(i)), 64'd0);
            check_eq("rst_misses", 64'(get_mc(i)), 64'd0);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // cold miss, hit, index conflict
        fetch(0, 32'h14, 0, -1, 0, -1);
        fetch(0, 32'h18, 0, -1, 0, -1);
        fetch(0, 32'h50, 0, -1, 0, -1);
        fetch(0, 32'h14, 0, -1, 0, -1);
        // flush in idle, flush on the capture edge
        pulse_flush();
        fetch(0, 32'h10, 0, -1, 0, -1);
        fetch(0, 32'h20, 0, MEM_WAIT, 0, -1);
        fetch(0, 32'h24, 0, -1, 0, -1);
        fetch(0, 32'h10, 0, -1, 0, -1);
        // reset while fill counter is 3, then a full-latency miss
        fetch(0, 32'h30, 0, -1, 0, 4);
        fetch(0, 32'h14, 0, -1, 0, -1);
        // held request across ready, saturating 2-bit counters
        for (int j = 0; j < 5; j++) fetch(1, 32'h100 * (j + 1) + 32'h4, 1, -1, 0, -1);
        req[1] = 1'b0;
        check_eq("sat_miss_count", 64'(mc1), 64'd3);
        // randomized traffic
        for (int j = 0; j < 40; j++) begin
            logic [31:0] ra;
            ra = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
            if ($urandom_range(0, 7) == 0) pulse_flush();
            fetch(0, ra, bit'($urandom_range(0, 1)), -1, bit'($urandom_range(0, 1)), -1);
        end
        req[0] = 1'b0;
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
